clarke_forward: RTL and testbench

- Forward Clarke transform, the companion to the inverse Clarke stage: phase quantities (Va, Vb, Vc) in, stationary-frame (Valpha, Vbeta) out.
- Sits on the current-feedback path between the ADC/phase-current capture and the Park transform.
- 3-stage pipeline with a valid bit, pipeline-wide enable stall, Q15 signed arithmetic, symmetric saturation and a sticky saturation flag.
- Theta is carried through, aligned with its sample.

---
 rtl/clarke_forward.sv | 196 +++++++++++++++++++
 tb/tb_clarke_forward.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/clarke_forward.sv
// Forward Clarke transform: (Va, Vb[, Vc]) phase samples in, (Valpha, Vbeta) out.
// Three-stage pipeline with a global enable, Q15 fixed point, symmetric saturation
// to +/-32767 and a sticky saturation flag. Theta rides alongside its sample untouched.
// Optional build macro: CLARKE_3IN_EN selects the three-input formula
// (Valpha = (2Va - Vb - Vc)/3, Vbeta = (Vb - Vc)/sqrt3); undefined gives the
// two-input formula (Valpha = Va, Vbeta = (Va + 2Vb)/sqrt3) and Vc is ignored.
//
// Handshake: a beat is transferred on every rising clk edge where enable=1 and the
// matching tvalid=1. There is no ready; the producer may present a sample on any
// enabled cycle and the consumer must take every m_axis_tvalid beat. enable=0
// freezes the whole pipeline, including the output beat and sat_flag.
module clarke_forward #(
    parameter logic [15:0] MAX_LIM   = 16'h7FFF,
    parameter logic [15:0] MIN_LIM   = 16'h8001,
    parameter logic [15:0] INV_SQRT3 = 16'd18918,
    parameter logic [15:0] INV_3     = 16'd10923
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        s_axis_tvalid,
    input  logic [63:0] s_axis,
    output logic        m_axis_tvalid,
    output logic [63:0] m_axis,
    input  logic        sat_clr,
    output logic        sat_flag
);

    // Saturation bounds widened to the product width so comparisons stay signed.
    localparam logic signed [33:0] MAX_EXT = {{18{MAX_LIM[15]}}, MAX_LIM};
    localparam logic signed [33:0] MIN_EXT = {{18{MIN_LIM[15]}}, MIN_LIM};
    localparam logic [33:0] COEF_SQRT3 = {18'd0, INV_SQRT3};

    // Input fields, sign-extended to the 18-bit stage-1 width.
    logic signed [17:0] va_x;
    logic signed [17:0] vb_x;
    logic [15:0]        in_theta;

    assign va_x     = {{2{s_axis[15]}}, s_axis[15:0]};
    assign vb_x     = {{2{s_axis[31]}}, s_axis[31:16]};
    assign in_theta = s_axis[63:48];

    // Pipeline registers common to both modes.
    logic               s1_valid_d, s1_valid_q;
    logic [15:0]        s1_theta_d, s1_theta_q;
    logic               s2_valid_d, s2_valid_q;
    logic [15:0]        s2_theta_d, s2_theta_q;
    logic signed [33:0] s2_prod_b_d, s2_prod_b_q;
    logic               m_valid_d, m_valid_q;
    logic [63:0]        m_data_d, m_data_q;
    logic               sat_flag_d, sat_flag_q;

`ifdef CLARKE_3IN_EN
    logic signed [17:0] vc_x;
    logic signed [17:0] s1_a_d, s1_a_q;
    logic signed [17:0] s1_b_d, s1_b_q;
    logic signed [33:0] s2_prod_a_d, s2_prod_a_q;
    localparam logic [33:0] COEF_3 = {18'd0, INV_3};

    assign vc_x = {{2{s_axis[47]}}, s_axis[47:32]};
`else
    logic signed [17:0] s1_sum_d, s1_sum_q;
    logic [15:0]        s1_va_d, s1_va_q;
    logic [15:0]        s2_va_d, s2_va_q;
    logic               unused_ok;

    // Vc and the 1/3 coefficient have no role in the two-input formula.
    assign unused_ok = ^{s_axis[47:32], INV_3};
`endif

    // Stage-3 arithmetic: unscaled results, clamp detection and clamped 16-bit values.
    logic signed [33:0] alpha_wide;
    logic signed [33:0] beta_wide;
    logic               alpha_hi, alpha_lo, beta_hi, beta_lo;
    logic [15:0]        alpha_out, beta_out;
    logic               sample_sat;

    // Scale back from Q15 products (floor) and clamp symmetrically.
    always_comb begin
`ifdef CLARKE_3IN_EN
        alpha_wide = s2_prod_a_q >>> 15;
`else
        alpha_wide = {{18{s2_va_q[15]}}, s2_va_q};
`endif
        beta_wide  = s2_prod_b_q >>> 15;
        alpha_hi   = alpha_wide > MAX_EXT;
        alpha_lo   = alpha_wide < MIN_EXT;
        beta_hi    = beta_wide > MAX_EXT;
        beta_lo    = beta_wide < MIN_EXT;
        alpha_out  = alpha_hi ? MAX_LIM : (alpha_lo ? MIN_LIM : alpha_wide[15:0]);
        beta_out   = beta_hi ? MAX_LIM : (beta_lo ? MIN_LIM : beta_wide[15:0]);
        sample_sat = s2_valid_q & (alpha_hi | alpha_lo | beta_hi | beta_lo);
    end

    // Next-state for every pipeline register; enable=0 holds all of them.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_theta_d  = s1_theta_q;
        s2_valid_d  = s2_valid_q;
        s2_theta_d  = s2_theta_q;
        s2_prod_b_d = s2_prod_b_q;
        m_valid_d   = m_valid_q;
        m_data_d    = m_data_q;
`ifdef CLARKE_3IN_EN
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s2_prod_a_d = s2_prod_a_q;
`else
        s1_sum_d    = s1_sum_q;
        s1_va_d     = s1_va_q;
        s2_va_d     = s2_va_q;
`endif
        if (enable) begin
            // Stage 1: capture and form the linear combinations.
            s1_valid_d  = s_axis_tvalid;
            s1_theta_d  = in_theta;
`ifdef CLARKE_3IN_EN
            s1_a_d      = va_x + va_x - vb_x - vc_x;
            s1_b_d      = vb_x - vc_x;
`else
            s1_sum_d    = va_x + vb_x + vb_x;
            s1_va_d     = s_axis[15:0];
`endif
            // Stage 2: Q15 coefficient multiplies.
            s2_valid_d  = s1_valid_q;
            s2_theta_d  = s1_theta_q;
`ifdef CLARKE_3IN_EN
            s2_prod_a_d = {{16{s1_a_q[17]}}, s1_a_q} * COEF_3;
            s2_prod_b_d = {{16{s1_b_q[17]}}, s1_b_q} * COEF_SQRT3;
`else
            s2_prod_b_d = {{16{s1_sum_q[17]}}, s1_sum_q} * COEF_SQRT3;
            s2_va_d     = s1_va_q;
`endif
            // Stage 3: pack the clamped result.
            m_valid_d   = s2_valid_q;
            m_data_d    = {16'h0000, s2_theta_q, beta_out, alpha_out};
        end
    end

    // Sticky flag: clear is honoured even while stalled, a new clamp event wins over clear.
    always_comb begin
        sat_flag_d = sat_flag_q;
        if (sat_clr) begin
            sat_flag_d = 1'b0;
        end
        if (enable && sample_sat) begin
            sat_flag_d = 1'b1;
        end
    end

    // Register update with synchronous reset clearing data and valid bits alike.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_theta_q  <= '0;
            s2_valid_q  <= 1'b0;
            s2_theta_q  <= '0;
            s2_prod_b_q <= '0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            sat_flag_q  <= 1'b0;
`ifdef CLARKE_3IN_EN
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s2_prod_a_q <= '0;
`else
            s1_sum_q    <= '0;
            s1_va_q     <= '0;
            s2_va_q     <= '0;
`endif
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_theta_q  <= s1_theta_d;
            s2_valid_q  <= s2_valid_d;
            s2_theta_q  <= s2_theta_d;
            s2_prod_b_q <= s2_prod_b_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            sat_flag_q  <= sat_flag_d;
`ifdef CLARKE_3IN_EN
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s2_prod_a_q <= s2_prod_a_d;
`else
            s1_sum_q    <= s1_sum_d;
            s1_va_q     <= s1_va_d;
            s2_va_q     <= s2_va_d;
`endif
        end
    end

    assign m_axis_tvalid = m_valid_q;
    assign m_axis        = m_data_q;
    assign sat_flag      = sat_flag_q;

endmodule

// File: tb/tb_clarke_forward.sv
// Directed bench for clarke_forward: reset state, latency, Q15 scaling with floor,
// saturation and sticky flag, stall behaviour and mid-flight reset.
module tb_clarke_forward;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        s_axis_tvalid;
    logic [63:0] s_axis;
    logic        m_axis_tvalid;
    logic [63:0] m_axis;
    logic        sat_clr;
    logic        sat_flag;

    int n_checks = 0;
    int n_fail   = 0;

    clarke_forward dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis        (s_axis),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis        (m_axis),
        .sat_clr       (sat_clr),
        .sat_flag      (sat_flag)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle before sampling or driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vld, input logic [15:0] va, input logic [15:0] vb,
                         input logic [15:0] vc, input logic [15:0] th);
        s_axis_tvalid = vld;
        s_axis        = {th, vc, vb, va};
    endtask

    task automatic idle();
        drive(1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pack(input logic [15:0] alpha, input logic [15:0] beta,
                                         input logic [15:0] th);
        return {16'h0000, th, beta, alpha};
    endfunction

    // One sample through an otherwise empty pipeline, checked after 3 enabled edges.
    task automatic run_sample(input string tag, input logic [15:0] va, input logic [15:0] vb,
                              input logic [15:0] vc, input logic [15:0] th,
                              input logic [63:0] exp_data, input logic exp_flag);
        drive(1'b1, va, vb, vc, th);
        step();
        idle();
        step();
        check({tag, "_early_valid"}, {63'd0, m_axis_tvalid}, 64'd0);
        step();
        check({tag, "_valid"}, {63'd0, m_axis_tvalid}, 64'd1);
        check({tag, "_data"}, m_axis, exp_data);
        check({tag, "_flag"}, {63'd0, sat_flag}, {63'd0, exp_flag});
    endtask

    initial begin
        rst     = 1'b1;
        enable  = 1'b1;
        sat_clr = 1'b0;
        idle();
        step();
        step();
        rst = 1'b0;
        check("reset_data", m_axis, 64'd0);
        check("reset_valid", {63'd0, m_axis_tvalid}, 64'd0);
        check("reset_flag", {63'd0, sat_flag}, 64'd0);

`ifdef CLARKE_3IN_EN
        // 3000,-1500,-1500 -> alpha 3000, beta 0
        run_sample("tri_a", 16'd3000, 16'hFA24, 16'hFA24, 16'h0101,
                   pack(16'h0BB8, 16'h0000, 16'h0101), 1'b0);
        // 0,1000,-1000 -> alpha 0, beta floor(2000*18918/32768)=1154
        run_sample("tri_b", 16'd0, 16'd1000, 16'hFC18, 16'h0202,
                   pack(16'h0000, 16'h0482, 16'h0202), 1'b0);
        // a = 2*32767 + 2*32768 = 131070 -> alpha clamps high, beta 0
        run_sample("tri_sat", 16'h7FFF, 16'h8000, 16'h8000, 16'h0303,
                   pack(16'h7FFF, 16'h0000, 16'h0303), 1'b1);
        sat_clr = 1'b1;
        step();
        sat_clr = 1'b0;
        check("tri_clr", {63'd0, sat_flag}, 64'd0);
`else
        // 4096 -> beta floor(4096*18918/32768)=2364
        run_sample("a", 16'h1000, 16'h0000, 16'h0000, 16'h1234,
                   pack(16'h1000, 16'h093C, 16'h1234), 1'b0);
        // Vb=256 -> beta floor(512*18918/32768)=295
        run_sample("b", 16'h0000, 16'h0100, 16'h5555, 16'h0001,
                   pack(16'h0000, 16'h0127, 16'h0001), 1'b0);
        // 98301*18918/32768 = 56752 -> clamps to 0x7FFF
        run_sample("c", 16'h7FFF, 16'h7FFF, 16'h0000, 16'h7FFF,
                   pack(16'h7FFF, 16'h7FFF, 16'h7FFF), 1'b1);

        // Clear while stalled: flag drops, output beat holds.
        enable  = 1'b0;
        sat_clr = 1'b1;
        step();
        sat_clr = 1'b0;
        check("clr_stalled_flag", {63'd0, sat_flag}, 64'd0);
        check("clr_stalled_data", m_axis, pack(16'h7FFF, 16'h7FFF, 16'h7FFF));
        check("clr_stalled_valid", {63'd0, m_axis_tvalid}, 64'd1);
        enable = 1'b1;

        // -32768 on both inputs: alpha clamps to 0x8001, beta -56754 clamps to 0x8001.
        // sat_clr coincides with the clamp event; the set must win.
        drive(1'b1, 16'h8000, 16'h8000, 16'h0000, 16'hABCD);
        step();
        idle();
        step();
        sat_clr = 1'b1;
        step();
        sat_clr = 1'b0;
        check("d_data", m_axis, pack(16'h8001, 16'h8001, 16'hABCD));
        check("d_valid", {63'd0, m_axis_tvalid}, 64'd1);
        check("d_flag_set_wins", {63'd0, sat_flag}, 64'd1);
        sat_clr = 1'b1;
        step();
        sat_clr = 1'b0;
        check("d_clr", {63'd0, sat_flag}, 64'd0);

        // Saturating data marked invalid must not touch the flag.
        drive(1'b0, 16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000);
        step();
        idle();
        step();
        step();
        check("inv_valid", {63'd0, m_axis_tvalid}, 64'd0);
        check("inv_flag", {63'd0, sat_flag}, 64'd0);

        // Back-to-back samples with enable 1,0,0,1,1,1 from the first output onward.
        // E1: 256,0 -> 147 ; E2: -256,0 -> floor(-147.8)=-148 ; E3: 0,-256 -> -296
        drive(1'b1, 16'h0100, 16'h0000, 16'h0000, 16'h0011);
        step();
        drive(1'b1, 16'hFF00, 16'h0000, 16'h0000, 16'h0022);
        step();
        drive(1'b1, 16'h0000, 16'hFF00, 16'h0000, 16'h0033);
        step();
        check("e1_data", m_axis, pack(16'h0100, 16'h0093, 16'h0011));
        check("e1_valid", {63'd0, m_axis_tvalid}, 64'd1);
        enable = 1'b0;
        drive(1'b1, 16'h7FFF, 16'h7FFF, 16'h0000, 16'h0EEE);
        for (int i = 0; i < 2; i++) begin
            step();
            check("stall_data", m_axis, pack(16'h0100, 16'h0093, 16'h0011));
            check("stall_valid", {63'd0, m_axis_tvalid}, 64'd1);
        end
        check("stall_flag", {63'd0, sat_flag}, 64'd0);
        enable = 1'b1;
        idle();
        step();
        check("e2_data", m_axis, pack(16'hFF00, 16'hFF6C, 16'h0022));
        check("e2_valid", {63'd0, m_axis_tvalid}, 64'd1);
        step();
        check("e3_data", m_axis, pack(16'h0000, 16'hFED8, 16'h0033));
        check("e3_valid", {63'd0, m_axis_tvalid}, 64'd1);
        step();
        check("e_drain_valid", {63'd0, m_axis_tvalid}, 64'd0);

        // Reset with three samples in flight, the oldest having just set the flag.
        drive(1'b1, 16'h7FFF, 16'h7FFF, 16'h0000, 16'h0044);
        step();
        drive(1'b1, 16'h1000, 16'h0000, 16'h0000, 16'h0055);
        step();
        drive(1'b1, 16'h0000, 16'h0100, 16'h0000, 16'h0066);
        step();
        check("pre_rst_flag", {63'd0, sat_flag}, 64'd1);
        rst = 1'b1;
        idle();
        step();
        rst = 1'b0;
        check("mid_rst_data", m_axis, 64'd0);
        check("mid_rst_valid", {63'd0, m_axis_tvalid}, 64'd0);
        check("mid_rst_flag", {63'd0, sat_flag}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_rst_valid", {63'd0, m_axis_tvalid}, 64'd0);
        end
        run_sample("after_rst", 16'h1000, 16'h0000, 16'h0000, 16'h1234,
                   pack(16'h1000, 16'h093C, 16'h1234), 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
